// File: rtl/perf_run_monitor.sv
// perf_run_monitor: run-control FSM, saturating cycle and event counters,
// watchdog, and a registered counter read port for a pipelined CPU.

// One saturating counter lane with a sticky overflow flag.
module perf_run_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         zero,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  // Zero on reset or run (re)arm; otherwise count and saturate at all-ones.
  always_ff @(posedge clk) begin
    if (reset || zero) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) ovf <= 1'b1;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

module perf_run_monitor #(
  parameter int CNT_WIDTH      = 32,
  parameter int NUM_EVENTS     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SEL_WIDTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  end_program,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [SEL_WIDTH-1:0]  rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [NUM_EVENTS:0]   overflow,
  output logic                  running,
  output logic                  done,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;

  localparam logic [63:0] TO_LIM = 64'(TIMEOUT_CYCLES);

  state_t state, state_nxt;

  // Lane 0 is the cycle counter, lane i+1 is event channel i.
  logic [NUM_EVENTS:0][CNT_WIDTH-1:0] cnt_arr;
  logic [NUM_EVENTS:0]                inc_vec;
  logic                               zero_all;
  logic                               in_run;
  logic [CNT_WIDTH-1:0]               cyc_post;
  logic                               to_hit;
  logic [CNT_WIDTH-1:0]               rd_next;

  // A clear in RUN wins over counting; start in IDLE rearms all lanes.
  assign in_run   = (state == RUN) && !clear;
  assign zero_all = clear || ((state == IDLE) && start);
  assign inc_vec  = {event_in & {NUM_EVENTS{in_run}}, in_run};

  // Cycle count as it will be after this edge, saturation included.
  assign cyc_post = (&cnt_arr[0]) ? cnt_arr[0] : cnt_arr[0] + 1'b1;
  assign to_hit   = (TIMEOUT_CYCLES != 0) && (64'(cyc_post) == TO_LIM);

  for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_lane
    perf_run_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .zero  (zero_all),
      .inc   (inc_vec[g]),
      .cnt   (cnt_arr[g]),
      .ovf   (overflow[g])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: clear first, then end_program beats the watchdog.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (end_program) state_nxt = DONE;
                 else if (to_hit) state_nxt = TIMEOUT;
        default: state_nxt = state;
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);
  assign timeout = (state == TIMEOUT);

  // Read mux over pre-edge counter values; out-of-range selects read 0.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i <= NUM_EVENTS; i++)
      if (rd_sel == SEL_WIDTH'(i)) rd_next = cnt_arr[i];
  end

  // Registered read data, one cycle behind rd_sel.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_next;
  end

endmodule

// File: tb/tb_perf_run_monitor.sv
// Bench: two monitor instances (32-bit with a 50-cycle watchdog, 4-bit with
// no watchdog) share one stimulus stream and are checked every cycle against
// a behavioural model, plus literal checks on the directed scenarios.
module tb_perf_run_monitor;

  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          reset, start, clear, end_program;
  logic [NE-1:0] event_in;
  logic [3:0]    rd_sel;

  logic [31:0] rd_a;
  logic [3:0]  rd_s;
  logic [NE:0] ovf_a, ovf_s;
  logic        run_a, done_a, to_a, run_s, done_s, to_s;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  perf_run_monitor #(.CNT_WIDTH(32), .NUM_EVENTS(NE), .TIMEOUT_CYCLES(50), .SEL_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .end_program(end_program),
    .event_in(event_in), .rd_sel(rd_sel), .rd_data(rd_a), .overflow(ovf_a),
    .running(run_a), .done(done_a), .timeout(to_a));

  perf_run_monitor #(.CNT_WIDTH(4), .NUM_EVENTS(NE), .TIMEOUT_CYCLES(0), .SEL_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .end_program(end_program),
    .event_in(event_in), .rd_sel(rd_sel), .rd_data(rd_s), .overflow(ovf_s),
    .running(run_s), .done(done_s), .timeout(to_s));

  // ---------------- behavioural model ----------------
  // st: 0 idle, 1 running, 2 finished normally, 3 watchdog abort
  longint mmax[2] = '{64'hFFFF_FFFF, 64'd15};
  longint mto[2]  = '{64'd50, 64'd0};
  longint mcnt[2][NE+1];
  bit     movf[2][NE+1];
  int     mst[2];
  longint mrd[2];

  task automatic m_zero(input int j);
    for (int c = 0; c <= NE; c++) begin mcnt[j][c] = 0; movf[j][c] = 0; end
  endtask

  task automatic m_bump(input int j, input int c);
    if (mcnt[j][c] == mmax[j]) movf[j][c] = 1;
    else mcnt[j][c] = mcnt[j][c] + 1;
  endtask

  initial begin
    for (int j = 0; j < 2; j++) begin m_zero(j); mst[j] = 0; mrd[j] = 0; end
  end

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (reset) begin
        m_zero(j); mst[j] = 0; mrd[j] = 0;
      end else begin
        longint rdn;
        rdn = (int'(rd_sel) <= NE) ? mcnt[j][rd_sel] : 0;
        if (clear) begin
          m_zero(j); mst[j] = 0;
        end else if (mst[j] == 0) begin
          if (start) begin m_zero(j); mst[j] = 1; end
        end else if (mst[j] == 1) begin
          m_bump(j, 0);
          for (int e = 0; e < NE; e++) if (event_in[e]) m_bump(j, e + 1);
          if (end_program) mst[j] = 2;
          else if (mto[j] != 0 && mcnt[j][0] == mto[j]) mst[j] = 3;
        end
        mrd[j] = rdn;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint ovf_bits(input int j);
    longint v = 0;
    for (int c = 0; c <= NE; c++) if (movf[j][c]) v = v | (longint'(1) << c);
    return v;
  endfunction

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("a.rd_data",  rd_a,   mrd[0]);
      chk("a.overflow", ovf_a,  ovf_bits(0));
      chk("a.running",  run_a,  mst[0] == 1);
      chk("a.done",     done_a, mst[0] == 2);
      chk("a.timeout",  to_a,   mst[0] == 3);
      chk("s.rd_data",  rd_s,   mrd[1]);
      chk("s.overflow", ovf_s,  ovf_bits(1));
      chk("s.running",  run_s,  mst[1] == 1);
      chk("s.done",     done_s, mst[1] == 2);
      chk("s.timeout",  to_s,   mst[1] == 3);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_in();
    reset = 0; start = 0; clear = 0; end_program = 0; event_in = '0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  // Runs n run edges after a start edge; end_program on the last one if fin.
  task automatic run_n(input int n, input bit fin, input int ev0_cnt);
    for (int i = 1; i <= n; i++) begin
      end_program = fin && (i == n);
      event_in = {3'b000, i <= ev0_cnt};
      tick();
    end
    end_program = 0; event_in = '0;
  endtask

  task automatic read_sel(input int s);
    rd_sel = 4'(s); tick();
  endtask

  initial begin
    idle_in(); rd_sel = 0;
    reset = 1; tick(2); reset = 0;
    armed = 1;

    // Reset then idle.
    tick(10);
    for (int s = 0; s <= 4; s++) begin
      read_sel(s);
      chk("idle.rd", rd_a, 0);
    end
    chk("idle.flags", {run_a, done_a, to_a, ovf_a}, 0);

    // Basic run: 37 cycles, 12 events on channel 0.
    do_start();
    run_n(37, 1, 12);
    read_sel(0);
    chk("basic.done", done_a, 1);
    chk("basic.cyc", rd_a, 37);
    chk("sat.cyc", rd_s, 15);
    chk("sat.ovf0", ovf_s[0], 1);
    read_sel(1);
    chk("basic.ev0", rd_a, 12);
    tick(20);
    read_sel(0);
    chk("basic.frozen", rd_a, 37);
    do_clear();
    tick();
    chk("clear.cyc_s", rd_s, 0);
    chk("clear.ovf_s", ovf_s, 0);

    // Watchdog: 50 edges without end_program.
    do_start();
    run_n(49, 0, 0);
    chk("wd.still_run", run_a, 1);
    run_n(1, 0, 0);
    chk("wd.timeout", to_a, 1);
    tick(5);
    read_sel(0);
    chk("wd.cyc", rd_a, 50);
    do_clear();

    // end_program on the 50th edge beats the watchdog.
    do_start();
    run_n(50, 1, 0);
    chk("wd.done_wins", {done_a, to_a}, 2'b10);
    do_clear();

    // start mid-run is ignored.
    do_start();
    run_n(4, 0, 0);
    start = 1; run_n(1, 0, 0); start = 0;
    run_n(15, 1, 0);
    read_sel(0);
    chk("prio.start_ign", rd_a, 20);

    // clear with end_program in RUN returns to idle with zeroed counters.
    do_clear();
    do_start();
    run_n(6, 0, 3);
    clear = 1; end_program = 1; tick(); clear = 0; end_program = 0;
    read_sel(0);
    chk("prio.clear_end", {rd_a, run_a, done_a}, 0);

    // start with clear in idle stays idle.
    start = 1; clear = 1; tick(); start = 0; clear = 0;
    chk("prio.start_clear", run_a, 0);

    // Mid-run reset then a fresh 8-cycle run.
    do_start();
    run_n(9, 0, 5);
    reset = 1; tick(); reset = 0;
    chk("rst.idle", {run_a, ovf_a, rd_a}, 0);
    do_start();
    run_n(8, 1, 0);
    read_sel(0);
    chk("rst.rerun", rd_a, 8);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      clear       = ($urandom_range(0, 59) == 0);
      start       = ($urandom_range(0, 7) == 0);
      end_program = ($urandom_range(0, 39) == 0);
      event_in    = NE'($urandom());
      rd_sel      = 4'($urandom_range(0, 15));
      tick();
    end
    idle_in();
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
